// File: rtl/rpn_calc_fsm.sv
// RPN calculator: operand stack with push, two-operand ALU ops, a one-level undo snapshot and error trap.
// An op commits one cycle after it is accepted; display is the only combinational output.
module rpn_calc_fsm #(
  parameter int C_WIDTH = 16,
  parameter int C_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enter,
  input  logic                         undo,
  input  logic                         op_mode,
  input  logic [C_WIDTH-1:0]           value,
  output logic [C_WIDTH-1:0]           display,
  output logic [3:0]                   flags,
  output logic [$clog2(C_DEPTH+1)-1:0] depth,
  output logic                         busy,
  output logic                         error
);

  localparam int DW = $clog2(C_DEPTH+1);

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_EXEC  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t               state_q;
  logic [C_WIDTH-1:0]   stack_q [C_DEPTH];
  logic [DW-1:0]        depth_q;
  logic [3:0]           flags_q;
  logic                 busy_q;
  logic                 error_q;

  logic [C_WIDTH-1:0]   a_q;
  logic [C_WIDTH-1:0]   b_q;
  logic [1:0]           opc_q;

  logic                 snap_vld_q;
  logic                 snap_op_q;
  logic [DW-1:0]        snap_depth_q;
  logic [C_WIDTH-1:0]   snap_entry_q;
  logic [3:0]           snap_flags_q;

  logic [C_WIDTH-1:0]   top_d;
  logic [C_WIDTH-1:0]   second_d;
  logic [C_WIDTH-1:0]   res_d;
  logic [3:0]           res_flags_d;
  logic [C_WIDTH:0]     sum_d;
  logic [C_WIDTH:0]     diff_d;
  logic                 carry_d;
  logic                 ovf_d;

  // Integer compares avoid index wrap when depth is small.
  always_comb begin
    top_d    = '0;
    second_d = '0;
    for (int i = 0; i < C_DEPTH; i++) begin
      if (int'(depth_q) == i + 1) top_d = stack_q[i];
      if (int'(depth_q) == i + 2) second_d = stack_q[i];
    end
  end

  always_comb begin
    sum_d   = {1'b0, a_q} + {1'b0, b_q};
    diff_d  = {1'b0, a_q} - {1'b0, b_q};
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (opc_q)
      2'b00: begin
        res_d   = sum_d[C_WIDTH-1:0];
        carry_d = sum_d[C_WIDTH];
        ovf_d   = (a_q[C_WIDTH-1] == b_q[C_WIDTH-1]) && (sum_d[C_WIDTH-1] != a_q[C_WIDTH-1]);
      end
      2'b01: begin
        res_d   = diff_d[C_WIDTH-1:0];
        carry_d = diff_d[C_WIDTH];
        ovf_d   = (a_q[C_WIDTH-1] != b_q[C_WIDTH-1]) && (diff_d[C_WIDTH-1] != a_q[C_WIDTH-1]);
      end
      2'b10:   res_d = a_q & b_q;
      default: res_d = a_q | b_q;
    endcase
    res_flags_d = {res_d[C_WIDTH-1], (res_d == '0), carry_d, ovf_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_READY;
      depth_q      <= '0;
      flags_q      <= '0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      opc_q        <= '0;
      snap_vld_q   <= 1'b0;
      snap_op_q    <= 1'b0;
      snap_depth_q <= '0;
      snap_entry_q <= '0;
      snap_flags_q <= '0;
      for (int i = 0; i < C_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      case (state_q)
        ST_READY: begin
          if (enter && !op_mode) begin
            if (int'(depth_q) == C_DEPTH) begin
              state_q <= ST_ERROR;
              error_q <= 1'b1;
            end else begin
              for (int i = 0; i < C_DEPTH; i++)
                if (int'(depth_q) == i) stack_q[i] <= value;
              depth_q      <= depth_q + DW'(1);
              snap_vld_q   <= 1'b1;
              snap_op_q    <= 1'b0;
              snap_depth_q <= depth_q;
              snap_entry_q <= second_d;
              snap_flags_q <= flags_q;
            end
          end else if (enter) begin
            if (int'(depth_q) < 2) begin
              state_q <= ST_ERROR;
              error_q <= 1'b1;
            end else begin
              a_q     <= second_d;
              b_q     <= top_d;
              opc_q   <= value[1:0];
              state_q <= ST_EXEC;
              busy_q  <= 1'b1;
            end
          end else if (undo && snap_vld_q) begin
            depth_q    <= snap_depth_q;
            flags_q    <= snap_flags_q;
            snap_vld_q <= 1'b0;
            if (snap_op_q) begin
              for (int i = 0; i < C_DEPTH; i++)
                if (int'(snap_depth_q) == i + 2) stack_q[i] <= snap_entry_q;
            end
          end
        end
        ST_EXEC: begin
          // The old top stays in its slot so an undo only needs to restore A.
          for (int i = 0; i < C_DEPTH; i++)
            if (int'(depth_q) == i + 2) stack_q[i] <= res_d;
          depth_q      <= depth_q - DW'(1);
          flags_q      <= res_flags_d;
          snap_vld_q   <= 1'b1;
          snap_op_q    <= 1'b1;
          snap_depth_q <= depth_q;
          snap_entry_q <= a_q;
          snap_flags_q <= flags_q;
          state_q      <= ST_READY;
          busy_q       <= 1'b0;
        end
        ST_ERROR: begin
          if (enter || undo) begin
            state_q <= ST_READY;
            error_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_READY;
          busy_q  <= 1'b0;
          error_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    display = '0;
    if (state_q == ST_ERROR)  display = '1;
    else if (!op_mode)        display = value;
    else if (depth_q != '0)   display = top_d;
  end

  assign flags = flags_q;
  assign depth = depth_q;
  assign busy  = busy_q;
  assign error = error_q;

endmodule

// File: tb/tb_rpn_calc_fsm.sv
// Directed bench for rpn_calc_fsm: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_rpn_calc_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enter = 1'b0;
  logic        undo = 1'b0;
  logic        op_mode = 1'b1;
  logic [15:0] value = '0;
  logic [15:0] display;
  logic [3:0]  flags;
  logic [2:0]  depth;
  logic        busy;
  logic        error;

  rpn_calc_fsm #(.C_WIDTH(16), .C_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .enter(enter), .undo(undo), .op_mode(op_mode),
    .value(value), .display(display), .flags(flags), .depth(depth),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] disp;
    logic [3:0]  flg;
    logic [2:0]  dep;
    logic        bsy;
    logic        err;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  logic  chk_req = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;

  always @(negedge clk) begin
    if (chk_req) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL monitor: check requested but scoreboard empty");
      end else begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_checks++;
        if (display !== e.disp || flags !== e.flg || depth !== e.dep ||
            busy !== e.bsy || error !== e.err) begin
          n_fail++;
          $display("FAIL %s: got disp=%h flags=%b depth=%0d busy=%b err=%b, expected disp=%h flags=%b depth=%0d busy=%b err=%b",
                   nm, display, flags, depth, busy, error, e.disp, e.flg, e.dep, e.bsy, e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enter = 1'b0; undo = 1'b0; op_mode = 1'b1; value = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [15:0] v);
    op_mode = 1'b0; value = v; enter = 1'b1;
    tick();
    enter = 1'b0; op_mode = 1'b1; value = '0;
  endtask

  task automatic do_op(input logic [1:0] c);
    op_mode = 1'b1; value = {14'b0, c}; enter = 1'b1;
    tick();
    enter = 1'b0; value = '0;
  endtask

  task automatic pulse_undo();
    undo = 1'b1;
    tick();
    undo = 1'b0;
  endtask

  task automatic check(input string nm, input logic [15:0] d, input logic [3:0] f,
                       input logic [2:0] dp, input logic b, input logic e);
    exp_t x;
    x = '{disp: d, flg: f, dep: dp, bsy: b, err: e};
    name_q.push_back(nm);
    exp_q.push_back(x);
    chk_req = 1'b1;
    @(negedge clk);
    #1 chk_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    check("reset_state", 16'h0000, 4'b0000, 3'd0, 1'b0, 1'b0);
    op_mode = 1'b0; value = 16'h1234;
    check("display_value_mode0", 16'h1234, 4'b0000, 3'd0, 1'b0, 1'b0);
    op_mode = 1'b1; value = '0;

    // 5 - 3
    push(16'd5);
    push(16'd3);
    check("push_two", 16'd3, 4'b0000, 3'd2, 1'b0, 1'b0);
    do_op(2'b01);
    check("sub_exec_busy", 16'd3, 4'b0000, 3'd2, 1'b1, 1'b0);
    check("sub_commit", 16'd2, 4'b0000, 3'd1, 1'b0, 1'b0);

    // 1 + FFFF wraps to zero with carry, then undo
    do_reset();
    push(16'h0001);
    push(16'hFFFF);
    do_op(2'b00);
    tick();
    check("add_carry_zero", 16'h0000, 4'b0110, 3'd1, 1'b0, 1'b0);
    pulse_undo();
    check("undo_op", 16'hFFFF, 4'b0000, 3'd2, 1'b0, 1'b0);
    pulse_undo();
    check("undo_twice_noop", 16'hFFFF, 4'b0000, 3'd2, 1'b0, 1'b0);

    do_reset();
    push(16'h7FFF);
    push(16'h0001);
    do_op(2'b00);
    tick();
    check("add_signed_ovf", 16'h8000, 4'b1001, 3'd1, 1'b0, 1'b0);

    // sub overflow, AND, OR chained on the running result
    do_reset();
    push(16'h8000);
    push(16'h0001);
    do_op(2'b01);
    tick();
    check("sub_signed_ovf", 16'h7FFF, 4'b0001, 3'd1, 1'b0, 1'b0);
    push(16'h0FF0);
    do_op(2'b10);
    tick();
    check("and_op", 16'h0FF0, 4'b0000, 3'd1, 1'b0, 1'b0);
    push(16'h8000);
    do_op(2'b11);
    tick();
    check("or_op", 16'h8FF0, 4'b1000, 3'd1, 1'b0, 1'b0);

    do_reset();
    push(16'd3);
    push(16'd5);
    do_op(2'b01);
    tick();
    check("sub_borrow", 16'hFFFE, 4'b1010, 3'd1, 1'b0, 1'b0);

    // Overflow into error and recovery
    do_reset();
    for (int i = 1; i <= 4; i++) push(16'(i));
    check("stack_full", 16'd4, 4'b0000, 3'd4, 1'b0, 1'b0);
    push(16'd5);
    check("overflow_error", 16'hFFFF, 4'b0000, 3'd4, 1'b0, 1'b1);
    pulse_undo();
    check("error_exit_undo", 16'd4, 4'b0000, 3'd4, 1'b0, 1'b0);
    pulse_undo();
    check("undo_after_error", 16'd3, 4'b0000, 3'd3, 1'b0, 1'b0);

    // Underflow, error exit by enter, then enter+undo together
    do_reset();
    push(16'd9);
    do_op(2'b00);
    check("underflow_error", 16'hFFFF, 4'b0000, 3'd1, 1'b0, 1'b1);
    do_op(2'b00);
    check("error_exit_enter", 16'd9, 4'b0000, 3'd1, 1'b0, 1'b0);
    op_mode = 1'b0; value = 16'h0022; enter = 1'b1; undo = 1'b1;
    tick();
    enter = 1'b0; undo = 1'b0; op_mode = 1'b1; value = '0;
    check("enter_beats_undo", 16'h0022, 4'b0000, 3'd2, 1'b0, 1'b0);

    // Reset during EXEC aborts the op
    do_reset();
    push(16'd5);
    push(16'd3);
    do_op(2'b00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_in_exec", 16'h0000, 4'b0000, 3'd0, 1'b0, 1'b0);
    pulse_undo();
    check("undo_after_rst", 16'h0000, 4'b0000, 3'd0, 1'b0, 1'b0);

    // Commands during EXEC are ignored
    do_reset();
    push(16'd2);
    push(16'd3);
    do_op(2'b00);
    op_mode = 1'b0; value = 16'h0077; enter = 1'b1; undo = 1'b1;
    tick();
    enter = 1'b0; undo = 1'b0; op_mode = 1'b1; value = '0;
    check("exec_ignores_cmds", 16'd5, 4'b0000, 3'd1, 1'b0, 1'b0);
    check("exec_ignores_cmds_hold", 16'd5, 4'b0000, 3'd1, 1'b0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
